fetch_ifid_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 35 +++
 rtl/fetch_ifid_stage_pc_reg.sv | 42 ++++
 rtl/fetch_ifid_stage.sv | 128 ++++++++++++
 tb/tb_fetch_ifid_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcode constants used by the
// fetch stage and the main decoder, the NOP encoding and the fetch FSM states.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_STOP  = 6'h3F;

    // All-zero word decodes as sll $0,$0,0, i.e. a NOP / pipeline bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch-stage FSM: running, draining after STOP, drained
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    // True when the word carries the STOP opcode
    function automatic logic is_stop_word(input logic [31:0] instr);
        return instr[31:26] == OP_STOP;
    endfunction

endpackage

// File: rtl/fetch_ifid_stage_pc_reg.sv
// Program counter with next-PC selection: redirect target (word aligned),
// hold, or sequential +4. Redirect has priority over advance.
module pc_reg #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic              advance,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] pc_val_reg;
    logic [ADDR_W-1:0] pc_next;

    // Sequential successor wraps naturally at 2^ADDR_W
    assign pc_plus4 = pc_val_reg + ADDR_W'(4);
    assign pc       = pc_val_reg;

    // Next-PC mux; redirect targets have their two low bits cleared
    always_comb begin
        pc_next = pc_val_reg;
        if (redirect) begin
            pc_next = redirect_pc & ~ADDR_W'(3);
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_val_reg <= RESET_PC;
        end else begin
            pc_val_reg <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage plus IF/ID pipeline register. Fetches a word per
// cycle, honours stall and redirect, and on a latched STOP opcode freezes the
// PC, feeds bubbles for DRAIN_CYCLES unstalled cycles, then raises sticky done.
module fetch_ifid_stage
    import mips_pkg::*;
#(
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC     = '0,
    parameter int unsigned          DRAIN_CYCLES = 4,
    parameter int unsigned          CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus4,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic              halted,
    output logic              done
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    fetch_state_t      state_reg;
    logic [CNT_W-1:0]  drain_cnt_reg;
    logic              done_reg;
    logic              ifid_valid_reg;
    logic [31:0]       ifid_instr_reg;
    logic [ADDR_W-1:0] ifid_pc_plus4_reg;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_stop;
    logic              pc_redirect;
    logic              pc_advance;

    assign fetch_stop  = is_stop_word(imem_rdata);
    // Redirect moves the PC in RUN and DRAIN; DONE is fully frozen
    assign pc_redirect = redirect_valid && (state_reg != DONE);
    // Sequential advance only on a latched, non-STOP word in RUN
    assign pc_advance  = (state_reg == RUN) && !stall && !fetch_stop;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .redirect    (pc_redirect),
        .advance     (pc_advance),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    // IF/ID register and RUN/DRAIN/DONE sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= RUN;
            drain_cnt_reg     <= '0;
            done_reg          <= 1'b0;
            ifid_valid_reg    <= 1'b0;
            ifid_instr_reg    <= NOP_INSTR;
            ifid_pc_plus4_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (redirect_valid) begin
                        ifid_valid_reg <= 1'b0;
                        ifid_instr_reg <= NOP_INSTR;
                    end else if (!stall) begin
                        ifid_valid_reg    <= 1'b1;
                        ifid_instr_reg    <= imem_rdata;
                        ifid_pc_plus4_reg <= pc_plus4;
                        if (fetch_stop) begin
                            drain_cnt_reg <= DRAIN_LOAD;
                            if (DRAIN_CYCLES == 0) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        // STOP was on the wrong path: resume fetching
                        ifid_valid_reg <= 1'b0;
                        ifid_instr_reg <= NOP_INSTR;
                        drain_cnt_reg  <= '0;
                        state_reg      <= RUN;
                    end else if (!stall) begin
                        ifid_valid_reg <= 1'b0;
                        ifid_instr_reg <= NOP_INSTR;
                        drain_cnt_reg  <= drain_cnt_reg - CNT_W'(1);
                        if (drain_cnt_reg == CNT_W'(1)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign imem_addr     = pc;
    assign ifid_valid    = ifid_valid_reg;
    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc_plus4 = ifid_pc_plus4_reg;
    assign opcode        = ifid_instr_reg[31:26];
    assign func          = ifid_instr_reg[5:0];
    assign halted        = (state_reg != RUN);
    assign done          = done_reg;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: a small instruction ROM answers imem_addr,
// expectations are queued per driven cycle and compared after the edge.
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        halted;
    logic        done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        halted;
        logic        done;
    } snap_t;

    snap_t sb[$];
    logic [31:0] rom [0:63];

    assign imem_rdata = rom[imem_addr[7:2]];

    always #5 clk = ~clk;

    fetch_ifid_stage #(
        .ADDR_W       (32),
        .RESET_PC     (32'h0),
        .DRAIN_CYCLES (4),
        .CNT_W        (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .opcode         (opcode),
        .func           (func),
        .halted         (halted),
        .done           (done)
    );

    function automatic snap_t mk(input logic [31:0] pc, input logic v, input logic [31:0] ins,
                                 input logic [31:0] pc4, input logic h, input logic d);
        snap_t s;
        s.pc = pc; s.valid = v; s.instr = ins; s.pc4 = pc4; s.halted = h; s.done = d;
        return s;
    endfunction

    // pc_plus4 of a bubble is don't-care, so it is only observed for valid entries
    function automatic snap_t observe(input snap_t e);
        snap_t o;
        o.pc = imem_addr; o.valid = ifid_valid; o.instr = ifid_instr;
        o.pc4 = e.valid ? ifid_pc_plus4 : e.pc4;
        o.halted = halted; o.done = done;
        return o;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("pc=%h v=%b instr=%h pc4=%h halted=%b done=%b",
                         s.pc, s.valid, s.instr, s.pc4, s.halted, s.done);
    endfunction

    task automatic rom_init();
        for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[0] = 32'h0022_1820;
        rom[1] = 32'h8C43_0004;
        rom[2] = 32'h2001_0005;
        rom[3] = 32'h0109_5020;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, queue its expectation, sample after the edge
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input snap_t e);
        stall = st; redirect_valid = rd; redirect_pc = rpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Plain fetches without expectations (used to reach a starting point)
    task automatic run_plain(input int n);
        stall = 1'b0; redirect_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t e, o;
        rst = 1'b1;
        #1;
        e = mk(32'h0, 0, 32'h0, 32'h0, 0, 0);
        o = observe(mk(32'h0, 1, 32'h0, 32'h0, 0, 0));
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_state got %s required %s", fmt(o), fmt(e));
        end
        checks++;
        if ({opcode, func} !== 12'h000) begin
            failures++;
            $display("FAIL reset_decode got opcode=%h func=%h required 00/00", opcode, func);
        end
        $display("reset: %s", fmt(o));
    endtask

    task automatic test_fetch();
        snap_t e, o;
        logic [11:0] dec [3];
        dec[0] = {6'd0, 6'h20}; dec[1] = {6'd35, 6'h04}; dec[2] = {6'd8, 6'h05};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, mk(32'(4*(i+1)), 1, rom[i], 32'(4*(i+1)), 0, 0));
            e = sb.pop_front(); o = observe(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL fetch%0d got %s required %s", i, fmt(o), fmt(e));
            end
            checks++;
            if ({opcode, func} !== dec[i]) begin
                failures++;
                $display("FAIL decode%0d got opcode=%h func=%h required %h/%h",
                         i, opcode, func, dec[i][11:6], dec[i][5:0]);
            end
            $display("fetch%0d: %s opcode=%h func=%h", i, fmt(o), opcode, func);
        end
    endtask

    task automatic test_stall_redirect();
        snap_t e, o;
        logic       st [7];
        logic       rd [7];
        logic [31:0] rp [7];
        snap_t      ex [7];
        do_reset();
        run_plain(2);
        st[0]=1; rd[0]=0; rp[0]=0;     ex[0]=mk(32'h8, 1, 32'h8C43_0004, 32'h8, 0, 0);
        st[1]=1; rd[1]=0; rp[1]=0;     ex[1]=mk(32'h8, 1, 32'h8C43_0004, 32'h8, 0, 0);
        st[2]=0; rd[2]=0; rp[2]=0;     ex[2]=mk(32'hC, 1, 32'h2001_0005, 32'hC, 0, 0);
        st[3]=0; rd[3]=0; rp[3]=0;     ex[3]=mk(32'h10, 1, 32'h0109_5020, 32'h10, 0, 0);
        st[4]=1; rd[4]=1; rp[4]=32'h43; ex[4]=mk(32'h40, 0, 32'h0, 32'h0, 0, 0);
        st[5]=0; rd[5]=0; rp[5]=0;     ex[5]=mk(32'h44, 1, 32'h2000_0010, 32'h44, 0, 0);
        st[6]=0; rd[6]=1; rp[6]=32'h0C; ex[6]=mk(32'h0C, 0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(st[i], rd[i], rp[i], ex[i]);
            e = sb.pop_front(); o = observe(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall_redirect%0d got %s required %s", i, fmt(o), fmt(e));
            end
            $display("stall_redirect%0d: st=%b rd=%b %s", i, st[i], rd[i], fmt(o));
        end
    endtask

    task automatic test_stop();
        snap_t e, o;
        logic  st [9];
        logic  rd [9];
        snap_t ex [9];
        rom[8] = 32'hFC00_0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, mk(32'(4*(i+1)), 1, rom[i], 32'(4*(i+1)), 0, 0));
            e = sb.pop_front(); o = observe(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop_pre%0d got %s required %s", i, fmt(o), fmt(e));
            end
        end
        // stalled STOP on the bus is not latched; then latch, drain with one stall, done
        st[0]=1; rd[0]=0; ex[0]=mk(32'h20, 1, 32'h2000_0007, 32'h20, 0, 0);
        st[1]=0; rd[1]=0; ex[1]=mk(32'h20, 1, 32'hFC00_0000, 32'h24, 1, 0);
        st[2]=0; rd[2]=0; ex[2]=mk(32'h20, 0, 32'h0, 32'h0, 1, 0);
        st[3]=1; rd[3]=0; ex[3]=mk(32'h20, 0, 32'h0, 32'h0, 1, 0);
        st[4]=0; rd[4]=0; ex[4]=mk(32'h20, 0, 32'h0, 32'h0, 1, 0);
        st[5]=0; rd[5]=0; ex[5]=mk(32'h20, 0, 32'h0, 32'h0, 1, 0);
        st[6]=0; rd[6]=0; ex[6]=mk(32'h20, 0, 32'h0, 32'h0, 1, 1);
        st[7]=1; rd[7]=1; ex[7]=mk(32'h20, 0, 32'h0, 32'h0, 1, 1);
        st[8]=0; rd[8]=1; ex[8]=mk(32'h20, 0, 32'h0, 32'h0, 1, 1);
        for (int i = 0; i < 9; i++) begin
            drive(st[i], rd[i], 32'h100, ex[i]);
            e = sb.pop_front(); o = observe(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop%0d got %s required %s", i, fmt(o), fmt(e));
            end
            $display("stop%0d: st=%b rd=%b %s", i, st[i], rd[i], fmt(o));
        end
    endtask

    task automatic test_wrong_path_stop();
        snap_t e, o;
        snap_t ex [3];
        logic  rd [3];
        do_reset();
        run_plain(8);
        rd[0]=0; ex[0]=mk(32'h20, 1, 32'hFC00_0000, 32'h24, 1, 0);
        rd[1]=1; ex[1]=mk(32'h100, 0, 32'h0, 32'h0, 0, 0);
        rd[2]=0; ex[2]=mk(32'h104, 1, 32'h0022_1820, 32'h104, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, rd[i], 32'h100, ex[i]);
            e = sb.pop_front(); o = observe(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wrong_path%0d got %s required %s", i, fmt(o), fmt(e));
            end
            $display("wrong_path%0d: rd=%b %s", i, rd[i], fmt(o));
        end
    endtask

    task automatic test_async_reset();
        snap_t e, o;
        do_reset();
        run_plain(10);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL pre_async_halted got %b required 1", halted);
        end
        #2;
        rst = 1'b1;
        #1;
        e = mk(32'h0, 0, 32'h0, 32'h0, 0, 0);
        o = observe(mk(32'h0, 1, 32'h0, 32'h0, 0, 0));
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL async_reset got %s required %s", fmt(o), fmt(e));
        end
        $display("async_reset: %s", fmt(o));
        @(negedge clk);
        rst = 1'b0;
        rom[8] = 32'h2000_0008;
    endtask

    task automatic test_wrap();
        snap_t e, o;
        snap_t ex [3];
        logic  rd [3];
        do_reset();
        rd[0]=1; ex[0]=mk(32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 0);
        rd[1]=0; ex[1]=mk(32'h0, 1, 32'h2000_003F, 32'h0, 0, 0);
        rd[2]=0; ex[2]=mk(32'h4, 1, 32'h0022_1820, 32'h4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, rd[i], 32'hFFFF_FFFE, ex[i]);
            e = sb.pop_front(); o = observe(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wrap%0d got %s required %s", i, fmt(o), fmt(e));
            end
            $display("wrap%0d: rd=%b %s", i, rd[i], fmt(o));
        end
    endtask

    initial begin
        rom_init();
        test_reset();
        test_fetch();
        test_stall_redirect();
        test_stop();
        test_wrong_path_stop();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
